// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types for the pearl clock-generator monitor: scheduler states and result record.
// No logic.
// No flow control.
package bsg_clk_gen_pearl_pkg;

   localparam int pearl_settle_cycles_lp   = 4;
   localparam int pearl_max_id_width_lp    = 8;
   localparam int pearl_max_count_width_lp = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      REPORT
   } pearl_state_e;

   // Fields are sized for the largest supported configuration; users fill the low bits.
   typedef struct packed {
      logic [pearl_max_id_width_lp-1:0]    id;
      logic [pearl_max_count_width_lp-1:0] count;
      logic                                overflow;
   } pearl_result_s;

endpackage

// File: rtl/bsg_clk_gen_pearl_monitor_sync.sv
// Two-flop synchronizer for one monitor clock plus a rising-edge detector.
// Latency: 2 clk_i cycles from input edge to edge_o pulse.
// No backpressure; edge_o is a single-cycle pulse, at most one per two cycles.
module bsg_clk_gen_pearl_monitor_sync
  (input  logic clk_i,
   input  logic reset_n_i,
   input  logic d_i,
   output logic edge_o);

   logic sync1_r, sync2_r, prev_r;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end
      else begin
         sync1_r <= d_i;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign edge_o = sync2_r & ~prev_r;

endmodule

// File: rtl/bsg_clk_gen_pearl_monitor_sched.sv
// Round-robin edge counter over divided monitor clocks; BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN selects saturating count.
// Latency: first result 1+4+window cycles after en_i is sampled (4 settle cycles, then window).
// Backpressure: result held in REPORT with v_o high until ready_i; nothing else advances meanwhile.
module bsg_clk_gen_pearl_monitor_sched
   import bsg_clk_gen_pearl_pkg::*;
 #(parameter int num_clks_p     = 4,
   parameter int window_width_p = 16,
   parameter int count_width_p  = 12,
   localparam int id_width_lp   = (num_clks_p > 1) ? $clog2(num_clks_p) : 1)
  (input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [num_clks_p-1:0]     clk_monitor_i,
   input  logic                      en_i,
   input  logic [window_width_p-1:0] window_i,
   output logic                      v_o,
   input  logic                      ready_i,
   output logic [id_width_lp-1:0]    id_o,
   output logic [count_width_p-1:0]  count_o,
   output logic                      overflow_o);

   pearl_state_e state_r, state_n;

   logic [id_width_lp-1:0]    ptr_r;
   logic [window_width_p-1:0] win_r;
   logic [window_width_p-1:0] timer_r;
   logic [count_width_p-1:0]  count_r;
   logic                      ovf_bit;

   logic mon_sel;
   logic edge_pulse;
   logic handshake;
   logic start_settle;
   logic timer_done;

   // Only the selected channel reaches the synchronizer; SETTLE flushes it after a switch.
   assign mon_sel = clk_monitor_i[ptr_r];

   bsg_clk_gen_pearl_monitor_sync sync
     (.clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (mon_sel),
      .edge_o    (edge_pulse));

   assign v_o        = (state_r == REPORT);
   assign handshake  = v_o & ready_i;
   assign timer_done = (timer_r == '0);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i)
         state_r <= IDLE;
      else
         state_r <= state_n;
   end

   always_comb begin
      state_n      = state_r;
      start_settle = 1'b0;
      unique case (state_r)
         IDLE: begin
            if (en_i) begin
               state_n      = SETTLE;
               start_settle = 1'b1;
            end
         end
         SETTLE: begin
            if (timer_done)
               state_n = MEASURE;
         end
         MEASURE: begin
            if (timer_done)
               state_n = REPORT;
         end
         REPORT: begin
            if (handshake) begin
               if (en_i) begin
                  state_n      = SETTLE;
                  start_settle = 1'b1;
               end
               else
                  state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN
   logic ovf_r;
   assign ovf_bit = ovf_r;
`else
   assign ovf_bit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         ptr_r   <= '0;
         win_r   <= '0;
         timer_r <= '0;
         count_r <= '0;
`ifdef BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN
         ovf_r   <= 1'b0;
`endif
      end
      else begin
         if (start_settle) begin
            win_r   <= (window_i == '0) ? window_width_p'(1) : window_i;
            timer_r <= window_width_p'(pearl_settle_cycles_lp - 1);
            count_r <= '0;
`ifdef BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN
            ovf_r   <= 1'b0;
`endif
         end
         else begin
            // The timer counts settle cycles, then is reloaded with the latched window.
            if (state_r == SETTLE) begin
               if (timer_done)
                  timer_r <= win_r - window_width_p'(1);
               else
                  timer_r <= timer_r - window_width_p'(1);
            end
            else if (state_r == MEASURE && !timer_done)
               timer_r <= timer_r - window_width_p'(1);

            if (state_r == MEASURE && edge_pulse) begin
`ifdef BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN
               if (count_r == '1)
                  ovf_r <= 1'b1;
               else
                  count_r <= count_r + count_width_p'(1);
`else
               count_r <= count_r + count_width_p'(1);
`endif
            end
         end

         if (handshake)
            ptr_r <= (ptr_r == id_width_lp'(num_clks_p - 1)) ? '0 : ptr_r + id_width_lp'(1);
      end
   end

   pearl_result_s result;

   always_comb begin
      result                           = '0;
      result.id[id_width_lp-1:0]       = ptr_r;
      result.count[count_width_p-1:0]  = count_r;
      result.overflow                  = ovf_bit;
   end

   assign id_o       = result.id[id_width_lp-1:0];
   assign count_o    = result.count[count_width_p-1:0];
   assign overflow_o = result.overflow;

   logic unused_result_bits;
   assign unused_result_bits = ^result;

endmodule

// File: tb/tb_bsg_clk_gen_pearl_monitor_sched.sv
// Bench for the pearl monitor scheduler: directed table, corner sequences, randomized run vs. waveform model.
module tb_bsg_clk_gen_pearl_monitor_sched;

   localparam int NC = 4;
   localparam int WW = 16;
   localparam int CW = 4;
   localparam int HIST = 16384;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          en = 1'b0;
   logic          ready = 1'b0;
   logic [WW-1:0] window = '0;
   logic [NC-1:0] mon = '0;
   logic          v;
   logic [1:0]    id;
   logic [CW-1:0] count;
   logic          ovf;

   bsg_clk_gen_pearl_monitor_sched #(
      .num_clks_p     (NC),
      .window_width_p (WW),
      .count_width_p  (CW)
   ) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .clk_monitor_i (mon),
      .en_i          (en),
      .window_i      (window),
      .v_o           (v),
      .ready_i       (ready),
      .id_o          (id),
      .count_o       (count),
      .overflow_o    (ovf)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Monitor clock generator, controlled by the main process through these knobs.
   int half_period = 0;
   bit rand_mode   = 1'b0;
   int gen_epoch   = 0;
   int seen_epoch  = 0;
   int ph_cnt [NC];

   always @(negedge clk) begin
      if (gen_epoch != seen_epoch) begin
         seen_epoch = gen_epoch;
         for (int c = 0; c < NC; c++) ph_cnt[c] = 0;
         mon = '0;
      end
      for (int c = 0; c < NC; c++) begin
         if (rand_mode)
            mon[c] = 1'($urandom_range(0, 1));
         else if (half_period == 0)
            mon[c] = 1'b0;
         else begin
            ph_cnt[c]++;
            if (ph_cnt[c] >= half_period) begin
               ph_cnt[c] = 0;
               mon[c] = ~mon[c];
            end
         end
      end
   end

   // Record what every monitor input looked like at each rising edge of clk.
   logic [NC-1:0] hist [0:HIST-1];
   int cyc = 0;
   always @(posedge clk) begin
      if (cyc < HIST) hist[cyc] <= mon;
      cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_tol(input string name, input int act, input int exp, input int tol);
      vectors++;
      if (act < exp - tol || act > exp + tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0;
      ready = 1'b0;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic set_clocks(input int h, input bit rnd);
      half_period = h;
      rand_mode = rnd;
      gen_epoch++;
   endtask

   function automatic int eff_win(input int w);
      return (w == 0) ? 1 : w;
   endfunction

   // Expected result from the recorded waveform: rising edges of channel ch seen by the
   // two-flop synchronizer during the window that starts four cycles after edge s.
   function automatic int edges_in_window(input int s, input int w, input int ch);
      int n = 0;
      for (int j = s + 3; j <= s + 2 + w; j++)
         if (hist[j][ch] && !hist[j-1][ch]) n++;
      return n;
   endfunction

   typedef struct {
      int win;
      int half;
      int exp_cnt;
      int tol;
      int exp_ovf;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int lat, got, first_edge, last_edge, n_rep;
      int id0, cnt0;
      int s, w, r_edge, e, exp_id, exp_cnt, exp_ovf, nedge, wn;
      bit exp_v, hs, r;

      tbl[0] = '{100, 5, 10, 1, 0};
`ifdef BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN
      tbl[1] = '{64, 1, 15, 0, 1};
`else
      tbl[1] = '{64, 1, 0, 0, 0};
`endif
      tbl[2] = '{0, 1, 0, 1, 0};
      tbl[3] = '{20, 2, 5, 1, 0};
      tbl[4] = '{10, 0, 0, 0, 0};
      tbl[5] = '{30, 3, 5, 1, 0};
      tbl[6] = '{24, 1, 12, 0, 0};

      do_reset();
      chk("reset_v", int'(v), 0);
      chk("reset_id", int'(id), 0);
      chk("reset_count", int'(count), 0);
      chk("reset_ovf", int'(ovf), 0);

      // Directed table: one measurement on channel 0, en_i pulsed for a single cycle.
      for (int t = 0; t < 7; t++) begin
         do_reset();
         set_clocks(tbl[t].half, 1'b0);
         tick();
         window = WW'(tbl[t].win);
         en = 1'b1;
         lat = 0;
         for (int n = 1; n <= 400; n++) begin
            tick();
            if (n == 1) en = 1'b0;
            if (v) begin lat = n; break; end
         end
         chk($sformatf("tbl%0d_latency", t), lat, 5 + eff_win(tbl[t].win));
         chk($sformatf("tbl%0d_id", t), int'(id), 0);
         chk_tol($sformatf("tbl%0d_count", t), int'(count), tbl[t].exp_cnt, tbl[t].tol);
         chk($sformatf("tbl%0d_ovf", t), int'(ovf), tbl[t].exp_ovf);
         ready = 1'b1;
         tick();
         chk($sformatf("tbl%0d_idle_after_ack", t), int'(v), 0);
         ready = 1'b0;
      end

      // Round robin with en_i held: ids 0,1,2,3,0 and 1+4+window spacing.
      do_reset();
      set_clocks(1, 1'b0);
      window = WW'(5);
      ready = 1'b1;
      en = 1'b1;
      n_rep = 0;
      first_edge = 0;
      last_edge = 0;
      for (int n = 1; n <= 200 && n_rep < 5; n++) begin
         tick();
         if (v) begin
            if (n_rep == 0) first_edge = n;
            else chk($sformatf("rr_gap%0d", n_rep), n - last_edge, 10);
            chk($sformatf("rr_id%0d", n_rep), int'(id), n_rep % NC);
            last_edge = n;
            n_rep++;
            if (n_rep == 5) en = 1'b0;
         end
      end
      chk("rr_reports", n_rep, 5);
      chk("rr_first_latency", first_edge, 10);
      tick();
      ready = 1'b0;

      // Stall in REPORT: outputs frozen for 20 cycles, then next channel after release.
      do_reset();
      set_clocks(2, 1'b0);
      window = WW'(8);
      en = 1'b1;
      got = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (v) begin got = 1; break; end
      end
      chk("stall_reached", got, 1);
      id0 = int'(id);
      cnt0 = int'(count);
      chk_tol("stall_count", cnt0, 2, 1);
      for (int n = 0; n < 20; n++) begin
         tick();
         chk("stall_v", int'(v), 1);
         chk("stall_id", int'(id), id0);
         chk("stall_count_hold", int'(count), cnt0);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("stall_release_v", int'(v), 0);
      lat = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (v) begin lat = n; break; end
      end
      chk("stall_next_latency", lat, 12);
      chk("stall_next_id", int'(id), 1);
      en = 1'b0;

      // Reset in the middle of a channel-1 measurement.
      do_reset();
      set_clocks(1, 1'b0);
      window = WW'(3);
      en = 1'b1;
      ready = 1'b1;
      got = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (v) begin got = 1; break; end
      end
      chk("rst_first_report", got, 1);
      window = WW'(10);
      tick();
      chk("rst_after_ack_v", int'(v), 0);
      for (int n = 0; n < 7; n++) tick();
      chk("rst_premeasure_id", int'(id), 1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("rst_v", int'(v), 0);
      chk("rst_id", int'(id), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_ovf", int'(ovf), 0);
      lat = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (v) begin lat = n; break; end
      end
      chk("rst_restart_latency", lat, 15);
      chk("rst_restart_id", int'(id), 0);
      en = 1'b0;
      ready = 1'b0;

      // Randomized run: random monitor bits, random ready_i and window_i, en_i held high.
      do_reset();
      set_clocks(0, 1'b1);
      wn = $urandom_range(0, 20);
      window = WW'(wn);
      en = 1'b1;
      tick();
      s = cyc - 1;
      w = eff_win(wn);
      r_edge = s + 4 + w;
      exp_id = 0;
      exp_v = 1'b0;
      exp_cnt = 0;
      exp_ovf = 0;
      chk("rnd_start_v", int'(v), 0);
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 3) != 0);
         wn = $urandom_range(0, 20);
         ready = r;
         window = WW'(wn);
         hs = exp_v && r;
         tick();
         e = cyc - 1;
         if (hs) begin
            s = e;
            w = eff_win(wn);
            r_edge = s + 4 + w;
            exp_id = (exp_id + 1) % NC;
         end
         exp_v = (e >= r_edge);
         chk("rnd_v", int'(v), int'(exp_v));
         if (exp_v) begin
            if (e == r_edge) begin
               nedge = edges_in_window(s, w, exp_id);
`ifdef BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN
               exp_cnt = (nedge > 15) ? 15 : nedge;
               exp_ovf = (nedge > 15) ? 1 : 0;
`else
               exp_cnt = nedge % 16;
               exp_ovf = 0;
`endif
            end
            chk("rnd_id", int'(id), exp_id);
            chk("rnd_count", int'(count), exp_cnt);
            chk("rnd_ovf", int'(ovf), exp_ovf);
         end
      end
      en = 1'b0;
      ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/bsg_clk_gen_pearl_monitor_sched.md
BSG_CLK_GEN_PEARL_MONITOR_SCHED -- requirements
Module: bsg_clk_gen_pearl_monitor_sched

Interface
REQ-001 SHALL have parameter num_clks_p, default 4, number of monitored (already divided) clocks.
REQ-002 SHALL have parameter window_width_p, default 16, width of measurement-window length.
REQ-003 SHALL have parameter count_width_p, default 12, width of edge-count result.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port clk_monitor_i  input  num_clks_p  divided monitor clocks, asynchronous to clk_i.
REQ-007 SHALL have port en_i  input  1  enable continuous round-robin measurement.
REQ-008 SHALL have port window_i  input  window_width_p  measurement window in clk_i cycles.
REQ-009 SHALL have port v_o  output  1  result valid.
REQ-010 SHALL have port ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port id_o  output  $clog2(num_clks_p) (min 1)  channel of result.
REQ-012 SHALL have port count_o  output  count_width_p  rising edges counted in window.
REQ-013 SHALL have port overflow_o  output  1  count exceeded range.

Function
REQ-014 SHALL implement FSM IDLE, SETTLE, MEASURE, REPORT.
REQ-015 IDLE: stays while en_i=0; on en_i=1, registers window_i (0 treated as 1), clears count/overflow, goes to SETTLE next cycle.
REQ-016 SETTLE: exactly 4 cycles, edge pulses ignored, flushing synchronizer after channel switch; then MEASURE.
REQ-017 MEASURE: exactly registered-window cycles; each cycle with edge pulse increments count; then REPORT.
REQ-018 Selected channel = current round-robin pointer; only that input feeds the synchronizer.
REQ-019 REPORT: v_o=1; id_o, count_o, overflow_o held stable until v_o&ready_i.
REQ-020 On v_o&ready_i: pointer advances (num_clks_p-1 wraps to 0); go to SETTLE if en_i=1, else IDLE.
REQ-021 en_i deassert mid SETTLE/MEASURE SHALL NOT abort; measurement completes and reports.
REQ-022 window_i changes outside IDLE/handshake SHALL NOT affect the running measurement; re-sampled on each entry to SETTLE.
REQ-023 Edge pulse = synchronized sample 1 while previous synchronized sample 0; max one per 2 cycles.
REQ-024 v_o=0 in all states but REPORT.

Reset
REQ-025 reset_n_i=0 at a clock edge SHALL force IDLE, pointer 0, v_o 0, id_o 0, count_o 0, overflow_o 0, synchronizer flops 0, regardless of state.
REQ-026 In-flight measurement at reset SHALL be discarded, never reported.

Configuration
REQ-027 Macro BSG_CLK_GEN_PEARL_MONITOR_SCHED_SATURATE_EN defined: count saturates at 2^count_width_p-1 and overflow_o sets on an edge while saturated, sticky until next SETTLE.
REQ-028 Macro undefined: count wraps modulo 2^count_width_p; overflow_o tied 0.

Structure
REQ-029 State enum and result struct {id, count, overflow} SHALL live in shared bsg_clk_gen_pearl_pkg.
REQ-030 Synchronizer (2 flops) plus edge detector SHALL be sub-module bsg_clk_gen_pearl_monitor_sync.
REQ-031 Input mux, FSM, counters, pointer stay in top module; no latches, no clock gating.

Verification
REQ-032 num_clks_p=4, ch0 rising edge every 10 cycles, window 100, en_i=1, ready_i=1 -> v_o with id_o=0, count_o 10 (+/-1).
REQ-033 en_i held 1, ready_i=1 -> consecutive id_o 0,1,2,3,0; first v_o exactly 1+4+window cycles after en_i sampled.
REQ-034 ready_i=0 for 20 cycles in REPORT -> v_o, id_o, count_o stable 20 cycles, no new SETTLE.
REQ-035 count_width_p=4, edge every 2 cycles, window 64 -> with macro count_o 15, overflow_o 1; without macro count_o 0, overflow_o 0.
REQ-036 reset_n_i=0 one cycle mid-MEASURE -> next cycle IDLE, v_o 0, pointer 0; restart reports id_o 0.
REQ-037 window_i=0 -> MEASURE lasts 1 cycle; v_o asserts 6 cycles after en_i sampled.
